// File: rtl/vote_pkg.sv
// Shared definitions for the multi-candidate voting controller:
// FSM state encoding, a constant clog2 and a one-hot test helper.
package vote_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CONFIRM  = 2'd1;
   localparam logic [1:0] COMMIT   = 2'd2;
   localparam logic [1:0] WAIT_REL = 2'd3;

   // Widest button vector the one-hot helper accepts (NUM_CAND <= 16).
   localparam int unsigned ONEHOT_W = 16;

   // Ceiling log2, usable in parameter and port width expressions.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
      return (v != '0) && ((v & (v - ONEHOT_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/vote_leader_scan.sv
// Registered leader scan over all candidate tallies.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   tallies       flattened NUM_CAND*CNT_W tally bus, candidate i at [i*CNT_W +: CNT_W]
//   leader_idx    lowest index holding the maximum tally
//   leader_valid  maximum tally is nonzero
//   leader_tie    two or more candidates share a nonzero maximum
module vote_leader_scan
   import vote_pkg::*;
#(
   parameter int unsigned NUM_CAND = 4,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned IDX_W    = clog2(NUM_CAND)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CAND*CNT_W-1:0] tallies,
   output logic [IDX_W-1:0]          leader_idx,
   output logic                      leader_valid,
   output logic                      leader_tie
);

   logic [CNT_W-1:0] max_c;
   logic [CNT_W-1:0] cur_c;
   logic [IDX_W-1:0] idx_c;
   logic             tie_c;

   // Strict '>' keeps the lowest index on equal tallies; a later equal
   // nonzero value only flags the tie.
   always_comb begin
      max_c = '0;
      cur_c = '0;
      idx_c = '0;
      tie_c = 1'b0;
      for (int i = 0; i < NUM_CAND; i++) begin
         cur_c = tallies[i*CNT_W +: CNT_W];
         if (cur_c > max_c) begin
            max_c = cur_c;
            idx_c = IDX_W'(i);
            tie_c = 1'b0;
         end else if ((cur_c == max_c) && (cur_c != '0)) begin
            tie_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         leader_idx   <= '0;
         leader_valid <= 1'b0;
         leader_tie   <= 1'b0;
      end else begin
         leader_idx   <= idx_c;
         leader_valid <= (max_c != '0);
         leader_tie   <= tie_c;
      end
   end

endmodule

// File: rtl/vote_ctrl_multi.sv
// Multi-candidate voting controller: one-hot press -> timed confirmation ->
// saturating per-candidate tally commit, with cancel, poll gate, re-press
// lockout, multi-press rejection, running total, leader/tie and readout.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   poll_open     votes accepted only while high
//   vote_btn      one level bit per candidate (debounced)
//   cancel        aborts a pending vote while confirming
//   rd_idx        candidate selected for readout
//   conf          one-hot confirmation lamp for the pending candidate
//   busy          high while confirming, committing or awaiting release
//   vote_err      one-cycle pulse on a multi-button press
//   rd_count      registered tally of rd_idx (0 for out-of-range index)
//   total         sum of all committed votes
//   leader_*      leader index, nonzero-max flag, tie flag
//   sat           sticky; a commit found its tally already at max
module vote_ctrl_multi
   import vote_pkg::*;
#(
   parameter int unsigned NUM_CAND     = 4,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned CONFIRM_TIME = 50_000_000,
   parameter int unsigned TMR_W        = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             poll_open,
   input  logic [NUM_CAND-1:0]              vote_btn,
   input  logic                             cancel,
   input  logic [clog2(NUM_CAND)-1:0]       rd_idx,
   output logic [NUM_CAND-1:0]              conf,
   output logic                             busy,
   output logic                             vote_err,
   output logic [CNT_W-1:0]                 rd_count,
   output logic [CNT_W+clog2(NUM_CAND)-1:0] total,
   output logic [clog2(NUM_CAND)-1:0]       leader_idx,
   output logic                             leader_valid,
   output logic                             leader_tie,
   output logic                             sat
);

   localparam int unsigned IDX_W = clog2(NUM_CAND);
   localparam int unsigned TOT_W = CNT_W + IDX_W;

   logic [1:0]       state, state_n;
   logic [IDX_W-1:0] idx, idx_n, btn_idx;
   logic [TMR_W-1:0] timer, timer_n;
   logic [NUM_CAND-1:0] conf_n;
   logic             busy_n;
   logic             vote_err_n;

   logic [CNT_W-1:0] tally [NUM_CAND];
   logic [CNT_W-1:0] sel_tally;
   logic [CNT_W-1:0] rd_sel;
   logic             at_max;
   logic [NUM_CAND*CNT_W-1:0] tally_flat;

   // Index of the pressed button (meaningful only when one-hot).
   always_comb begin
      btn_idx = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (vote_btn[i]) btn_idx = IDX_W'(i);
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      timer_n    = timer;
      vote_err_n = 1'b0;
      conf_n     = '0;
      case (state)
         IDLE: begin
            if (poll_open && (vote_btn != '0)) begin
               if (is_onehot(ONEHOT_W'(vote_btn))) begin
                  idx_n   = btn_idx;
                  timer_n = '0;
                  state_n = CONFIRM;
               end else begin
                  vote_err_n = 1'b1;
                  state_n    = WAIT_REL;
               end
            end
         end
         CONFIRM: begin
            // Abort wins over the final confirmation cycle.
            if (cancel || !poll_open) begin
               state_n = WAIT_REL;
            end else if (timer == TMR_W'(CONFIRM_TIME - 1)) begin
               state_n = COMMIT;
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         COMMIT:   state_n = WAIT_REL;
         WAIT_REL: begin
            if (vote_btn == '0) state_n = IDLE;
         end
         default:  state_n = IDLE;
      endcase
      for (int i = 0; i < NUM_CAND; i++) begin
         conf_n[i] = (state_n == CONFIRM) && (idx_n == IDX_W'(i));
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         timer    <= '0;
         conf     <= '0;
         busy     <= 1'b0;
         vote_err <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         timer    <= timer_n;
         conf     <= conf_n;
         busy     <= busy_n;
         vote_err <= vote_err_n;
      end
   end

   // Tally of the pending candidate and of the readout index; an index
   // beyond NUM_CAND matches nothing and reads 0.
   always_comb begin
      sel_tally = '0;
      rd_sel    = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (idx == IDX_W'(i))    sel_tally = tally[i];
         if (rd_idx == IDX_W'(i)) rd_sel    = tally[i];
      end
      at_max = (sel_tally == '1);
   end

   // Commit: saturating increment, total follows only real increments.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
         total <= '0;
         sat   <= 1'b0;
      end else if (state == COMMIT) begin
         if (at_max) begin
            sat <= 1'b1;
         end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
               if (idx == IDX_W'(i)) tally[i] <= tally[i] + CNT_W'(1);
            end
            total <= total + TOT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rd_count <= '0;
      else       rd_count <= rd_sel;
   end

   always_comb begin
      tally_flat = '0;
      for (int i = 0; i < NUM_CAND; i++) tally_flat[i*CNT_W +: CNT_W] = tally[i];
   end

   vote_leader_scan #(
      .NUM_CAND (NUM_CAND),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W)
   ) u_leader (
      .clk          (clk),
      .reset        (reset),
      .tallies      (tally_flat),
      .leader_idx   (leader_idx),
      .leader_valid (leader_valid),
      .leader_tie   (leader_tie)
   );

endmodule

// File: tb/tb_vote_ctrl_multi.sv
// Directed self-checking bench for vote_ctrl_multi (NUM_CAND=4, CNT_W=3,
// CONFIRM_TIME=4) plus a NUM_CAND=3 instance for out-of-range readout.
module tb_vote_ctrl_multi;

   logic       clk;
   logic       reset;
   logic       poll_open;
   logic [3:0] vote_btn;
   logic       cancel;
   logic [1:0] rd_idx;
   logic [3:0] conf;
   logic       busy;
   logic       vote_err;
   logic [2:0] rd_count;
   logic [4:0] total;
   logic [1:0] leader_idx;
   logic       leader_valid;
   logic       leader_tie;
   logic       sat;

   logic       poll3;
   logic [2:0] vote_btn3;
   logic       cancel3;
   logic [1:0] rd_idx3;
   logic [2:0] conf3;
   logic       busy3;
   logic       vote_err3;
   logic [2:0] rd_count3;
   logic [4:0] total3;
   logic [1:0] leader_idx3;
   logic       leader_valid3;
   logic       leader_tie3;
   logic       sat3;

   int n_checks;
   int n_pass;

   vote_ctrl_multi #(.NUM_CAND(4), .CNT_W(3), .CONFIRM_TIME(4), .TMR_W(8)) dut (
      .clk(clk), .reset(reset), .poll_open(poll_open), .vote_btn(vote_btn),
      .cancel(cancel), .rd_idx(rd_idx), .conf(conf), .busy(busy),
      .vote_err(vote_err), .rd_count(rd_count), .total(total),
      .leader_idx(leader_idx), .leader_valid(leader_valid),
      .leader_tie(leader_tie), .sat(sat)
   );

   vote_ctrl_multi #(.NUM_CAND(3), .CNT_W(3), .CONFIRM_TIME(4), .TMR_W(8)) dut3 (
      .clk(clk), .reset(reset), .poll_open(poll3), .vote_btn(vote_btn3),
      .cancel(cancel3), .rd_idx(rd_idx3), .conf(conf3), .busy(busy3),
      .vote_err(vote_err3), .rd_count(rd_count3), .total(total3),
      .leader_idx(leader_idx3), .leader_valid(leader_valid3),
      .leader_tie(leader_tie3), .sat(sat3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vote_btn = '0;
      cancel = 1'b0;
      poll_open = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // One-cycle press then release; returns once the controller is idle again.
   task automatic do_vote(input logic [3:0] m);
      int k;
      vote_btn = m;
      step();
      vote_btn = '0;
      k = 0;
      while (busy && (k < 40)) begin
         step();
         k++;
      end
      if (busy) begin
         n_checks++;
         $display("FAIL vote_timeout: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++; if (conf !== 4'b0) $display("FAIL rst_conf: got %b exp 0000", conf); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
      n_checks++; if (vote_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", vote_err); else n_pass++;
      n_checks++; if (rd_count !== 3'd0) $display("FAIL rst_rd: got %0d exp 0", rd_count); else n_pass++;
      n_checks++; if (total !== 5'd0) $display("FAIL rst_total: got %0d exp 0", total); else n_pass++;
      n_checks++; if ({leader_valid, leader_tie, leader_idx} !== 4'b0) $display("FAIL rst_leader: got %b exp 0000", {leader_valid, leader_tie, leader_idx}); else n_pass++;
      n_checks++; if (sat !== 1'b0) $display("FAIL rst_sat: got %b exp 0", sat); else n_pass++;
      n_checks++; if ({conf3, busy3, vote_err3, rd_count3, total3, leader_idx3, leader_valid3, leader_tie3, sat3} !== 19'b0)
         $display("FAIL rst_dut3: got %b exp 0", {conf3, busy3, vote_err3, rd_count3, total3, leader_idx3, leader_valid3, leader_tie3, sat3});
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single_vote();
      do_reset();
      rd_idx = 2'd1;
      vote_btn = 4'b0010;
      step();
      vote_btn = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         n_checks++; if (conf !== 4'b0010) $display("FAIL single_conf%0d: got %b exp 0010", k, conf); else n_pass++;
         if (k < 4) step();
      end
      step();
      n_checks++; if (conf !== 4'b0000) $display("FAIL single_conf_off: got %b exp 0000", conf); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_commit: got %b exp 1", busy); else n_pass++;
      n_checks++; if (total !== 5'd0) $display("FAIL single_total_pre: got %0d exp 0", total); else n_pass++;
      step();
      n_checks++; if (total !== 5'd1) $display("FAIL single_total: got %0d exp 1", total); else n_pass++;
      n_checks++; if (leader_valid !== 1'b0) $display("FAIL single_leader_early: got %b exp 0", leader_valid); else n_pass++;
      step();
      n_checks++; if ({leader_valid, leader_idx} !== 3'b101) $display("FAIL single_leader: got %b exp 101", {leader_valid, leader_idx}); else n_pass++;
      n_checks++; if (rd_count !== 3'd1) $display("FAIL single_rd: got %0d exp 1", rd_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_cancel();
      do_reset();
      rd_idx = 2'd2;
      vote_btn = 4'b0100;
      step();
      vote_btn = 4'b0000;
      n_checks++; if (conf !== 4'b0100) $display("FAIL cancel_conf1: got %b exp 0100", conf); else n_pass++;
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      n_checks++; if (conf !== 4'b0000) $display("FAIL cancel_conf_drop: got %b exp 0000", conf); else n_pass++;
      for (int k = 0; k < 8; k++) step();
      n_checks++; if (total !== 5'd0) $display("FAIL cancel_total: got %0d exp 0", total); else n_pass++;
      n_checks++; if (rd_count !== 3'd0) $display("FAIL cancel_tally2: got %0d exp 0", rd_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL cancel_idle: got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_multi_press();
      do_reset();
      vote_btn = 4'b0101;
      step();
      vote_btn = 4'b0000;
      n_checks++; if (vote_err !== 1'b1) $display("FAIL multi_err: got %b exp 1", vote_err); else n_pass++;
      n_checks++; if (conf !== 4'b0000) $display("FAIL multi_conf: got %b exp 0000", conf); else n_pass++;
      step();
      n_checks++; if (vote_err !== 1'b0) $display("FAIL multi_err_pulse: got %b exp 0", vote_err); else n_pass++;
      n_checks++; if (total !== 5'd0) $display("FAIL multi_total: got %0d exp 0", total); else n_pass++;
      // Held button: one commit, then parked until release.
      vote_btn = 4'b0001;
      for (int k = 0; k < 20; k++) step();
      n_checks++; if (total !== 5'd1) $display("FAIL hold_total: got %0d exp 1", total); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL hold_busy: got %b exp 1", busy); else n_pass++;
      vote_btn = 4'b0000;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL hold_release: got %b exp 0", busy); else n_pass++;
      do_vote(4'b0001);
      n_checks++; if (total !== 5'd2) $display("FAIL hold_revote: got %0d exp 2", total); else n_pass++;
   endtask

   task automatic test_saturation_tie();
      do_reset();
      rd_idx = 2'd0;
      for (int k = 0; k < 7; k++) do_vote(4'b0001);
      n_checks++; if (sat !== 1'b0) $display("FAIL sat_early: got %b exp 0", sat); else n_pass++;
      n_checks++; if (total !== 5'd7) $display("FAIL sat_total7: got %0d exp 7", total); else n_pass++;
      do_vote(4'b0001);
      n_checks++; if (sat !== 1'b1) $display("FAIL sat_set: got %b exp 1", sat); else n_pass++;
      n_checks++; if (total !== 5'd7) $display("FAIL sat_total_hold: got %0d exp 7", total); else n_pass++;
      n_checks++; if (rd_count !== 3'd7) $display("FAIL sat_tally0: got %0d exp 7", rd_count); else n_pass++;
      for (int k = 0; k < 6; k++) do_vote(4'b1000);
      n_checks++; if ({leader_tie, leader_idx} !== 3'b000) $display("FAIL tie_early: got %b exp 000", {leader_tie, leader_idx}); else n_pass++;
      do_vote(4'b1000);
      n_checks++; if ({leader_valid, leader_tie, leader_idx} !== 4'b1100) $display("FAIL tie_set: got %b exp 1100", {leader_valid, leader_tie, leader_idx}); else n_pass++;
      n_checks++; if (total !== 5'd14) $display("FAIL tie_total: got %0d exp 14", total); else n_pass++;
      n_checks++; if (sat !== 1'b1) $display("FAIL sat_sticky: got %b exp 1", sat); else n_pass++;
   endtask

   task automatic test_poll_gate();
      do_reset();
      poll_open = 1'b0;
      vote_btn = 4'b0010;
      step();
      n_checks++; if ({busy, conf} !== 5'b0) $display("FAIL poll_closed: got %b exp 00000", {busy, conf}); else n_pass++;
      step();
      vote_btn = 4'b0000;
      poll_open = 1'b1;
      step();
      vote_btn = 4'b1000;
      step();
      vote_btn = 4'b0000;
      n_checks++; if (conf !== 4'b1000) $display("FAIL poll_conf: got %b exp 1000", conf); else n_pass++;
      step();
      poll_open = 1'b0;
      step();
      n_checks++; if (conf !== 4'b0000) $display("FAIL poll_drop_conf: got %b exp 0000", conf); else n_pass++;
      poll_open = 1'b1;
      for (int k = 0; k < 8; k++) step();
      n_checks++; if (total !== 5'd0) $display("FAIL poll_drop_total: got %0d exp 0", total); else n_pass++;
      n_checks++; if (leader_valid !== 1'b0) $display("FAIL poll_drop_leader: got %b exp 0", leader_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_confirm();
      do_reset();
      rd_idx = 2'd0;
      do_vote(4'b0001);
      do_vote(4'b0001);
      n_checks++; if (total !== 5'd2) $display("FAIL rmid_pre_total: got %0d exp 2", total); else n_pass++;
      vote_btn = 4'b0010;
      step();
      vote_btn = 4'b0000;
      step();
      step();
      n_checks++; if (conf !== 4'b0010) $display("FAIL rmid_conf3: got %b exp 0010", conf); else n_pass++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if ({conf, busy, vote_err, rd_count, total, leader_idx, leader_valid, leader_tie, sat} !== 19'b0)
         $display("FAIL rmid_all_zero: got %b exp 0", {conf, busy, vote_err, rd_count, total, leader_idx, leader_valid, leader_tie, sat});
      else n_pass++;
      step();
      n_checks++; if (rd_count !== 3'd0) $display("FAIL rmid_tally_cleared: got %0d exp 0", rd_count); else n_pass++;
   endtask

   task automatic test_readout();
      int k;
      do_reset();
      do_vote(4'b0010);
      do_vote(4'b0010);
      rd_idx = 2'd1;
      step();
      n_checks++; if (rd_count !== 3'd2) $display("FAIL rd_idx1: got %0d exp 2", rd_count); else n_pass++;
      rd_idx = 2'd0;
      step();
      n_checks++; if (rd_count !== 3'd0) $display("FAIL rd_idx0: got %0d exp 0", rd_count); else n_pass++;
      vote_btn3 = 3'b100;
      step();
      vote_btn3 = 3'b000;
      k = 0;
      while (busy3 && (k < 40)) begin
         step();
         k++;
      end
      if (busy3) begin
         n_checks++;
         $display("FAIL rd3_timeout: busy=%b required 0", busy3);
      end
      rd_idx3 = 2'd2;
      step();
      n_checks++; if (rd_count3 !== 3'd1) $display("FAIL rd3_idx2: got %0d exp 1", rd_count3); else n_pass++;
      rd_idx3 = 2'd3;
      step();
      n_checks++; if (rd_count3 !== 3'd0) $display("FAIL rd3_oob: got %0d exp 0", rd_count3); else n_pass++;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      poll_open = 1'b1;
      vote_btn  = '0;
      cancel    = 1'b0;
      rd_idx    = '0;
      poll3     = 1'b1;
      vote_btn3 = '0;
      cancel3   = 1'b0;
      rd_idx3   = '0;
      test_reset();
      test_single_vote();
      test_cancel();
      test_multi_press();
      test_saturation_tie();
      test_poll_gate();
      test_reset_mid_confirm();
      test_readout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vote_ctrl_multi.md
Name: vote_ctrl_multi

Overview:
Parametrised successor to the fixed three-candidate voting controller. Accepts one-hot vote buttons for NUM_CAND candidates, shows a timed confirmation per vote, and commits it to a saturating per-candidate tally. Adds vote cancel, a poll-open gate, re-press lockout, multi-press rejection, total and leader/tie outputs, and an indexed tally readout. It feeds the digit/seven-segment display path through rd_count.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 10, width of each candidate tally
CONFIRM_TIME, 50_000_000, cycles that conf is held before commit (>=1)
TMR_W, 32, confirm timer width; must hold CONFIRM_TIME

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; one clock
poll_open  in  1  votes accepted only while high
vote_btn  in  NUM_CAND  one bit per candidate, level (already debounced)
cancel  in  1  aborts a pending vote
rd_idx  in  clog2(NUM_CAND)  candidate selected for readout
conf  out  NUM_CAND  one-hot; lit for the candidate being confirmed
busy  out  1  high in CONFIRM, COMMIT and WAIT_REL
vote_err  out  1  one-cycle pulse on a rejected press
rd_count  out  CNT_W  registered tally of rd_idx
total  out  CNT_W+clog2(NUM_CAND)  sum of all committed votes
leader_idx  out  clog2(NUM_CAND)  lowest index holding the max tally
leader_valid  out  1  max tally > 0
leader_tie  out  1  two or more candidates share a nonzero max
sat  out  1  sticky; a commit hit a tally already at max

Behaviour:
- Reset values: all tallies, total, timer, conf, busy, vote_err, rd_count, leader_* and sat are 0; state is IDLE.
- IDLE:
  - Acts only if poll_open=1 and vote_btn!=0.
  - Exactly one bit set: latch its index, clear the timer, go to CONFIRM.
  - More than one bit set: pulse vote_err for one cycle, go to WAIT_REL, commit nothing.
- CONFIRM:
  - conf[idx]=1 and the timer increments each cycle.
  - When timer==CONFIRM_TIME-1, go to COMMIT. conf is therefore high for exactly CONFIRM_TIME cycles.
  - cancel=1 or poll_open=0 on any CONFIRM cycle: go to WAIT_REL next edge, no commit.
  - vote_btn changes during CONFIRM are ignored.
- COMMIT (one cycle, conf=0):
  - tally[idx] increments, saturating at 2^CNT_W-1; total increments by 1.
  - If tally[idx] was already at max: no increment to either tally or total, and sat sets.
  - Go to WAIT_REL.
- WAIT_REL:
  - Stay until vote_btn==0, then go to IDLE.
  - This blocks auto-repeat from a held button.
- cancel in IDLE or WAIT_REL has no effect.
- rd_count = tally[rd_idx], registered, 1-cycle latency. rd_idx >= NUM_CAND reads 0.
- Leader outputs are registered and update on the cycle after COMMIT. All tallies zero gives leader_valid=0, leader_idx=0, leader_tie=0.
- Reset mid-CONFIRM discards the pending vote and clears all tallies on that edge.
- Minimum vote-to-vote spacing is CONFIRM_TIME+3 cycles: CONFIRM_TIME + COMMIT + WAIT_REL + IDLE.

Decomposition:
- Package vote_pkg holds:
  - state encoding IDLE/CONFIRM/COMMIT/WAIT_REL
  - a clog2 constant function
  - an is_onehot helper
- One sub-module, vote_leader_scan: registered max/argmax/tie over a flattened NUM_CAND*CNT_W tally bus.

Test Plan:
- Bench parameters for all scenarios: NUM_CAND=4, CNT_W=3, CONFIRM_TIME=4.
- Single vote: poll_open=1, vote_btn=0010 for 1 cycle then 0 -> conf=0010 for exactly 4 cycles; tally[1]=1 and total=1 on the next edge; leader_idx=1, leader_valid=1 one cycle later.
- Cancel: vote_btn=0100, cancel pulsed on the 2nd conf cycle -> conf drops next edge; tally[2]=0, total=0; no commit.
- Multi-press and lockout:
  - vote_btn=0101 -> vote_err pulse, conf stays 0, no tally change.
  - Holding vote_btn=0001 through a full vote -> exactly 1 committed until release.
- Saturation and tie:
  - 8 votes for cand 0 -> tally[0]=7, sat=1 after the 8th, total=7.
  - Then 7 votes for cand 3 -> leader_tie=1, leader_idx=0.
- Poll gate and reset:
  - poll_open=0 press -> ignored.
  - poll_open dropped mid-CONFIRM -> no commit.
  - reset on the 3rd conf cycle -> every output is 0 next edge.
- Readout: rd_idx=1 after 2 votes for cand 1 -> rd_count=2 one cycle later; with NUM_CAND=3 instance and rd_idx=3 -> rd_count=0.
